// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Decoupled instruction-fetch front end for the RV32I core. Owns the fetch
// PC, issues word requests to instruction memory over req/gnt/rvalid, and
// buffers returned instructions with their PCs in a DEPTH-entry FIFO that
// feeds decode one instruction per cycle. A redirect from execute flushes
// the FIFO and squashes every response still in flight.
//
// Parameters
//   DEPTH     FIFO entries (power of two, 2..16); also caps buffered plus
//             in-flight fetches.
//   RESET_PC  fetch PC after reset.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   imem_req/imem_addr  fetch request and word-aligned byte address
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/rdata   in-order response for the oldest granted request
//   redirect_valid/pc   flush and restart fetch at redirect_pc (bits [1:0]
//                       forced to 0)
//   inst_valid/data/pc  FIFO head toward decode
//   inst_ready          decode consumes the head this cycle
//
// Build option
//   IFU_PERF_EN  when defined, adds perf_fetched (FIFO pushes) and
//                perf_squashed (discarded responses) 32-bit counters.
//
// Handshakes: a request transfers only on a cycle with imem_req & imem_gnt;
// req/addr are not sticky and may change freely while gnt is low. The decode
// port transfers on inst_valid & inst_ready; inst_valid/data/pc are driven
// purely from registered state, so they never depend on inst_ready.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_squashed
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    // Registered state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [PW-1:0] fifo_wptr_q, fifo_wptr_d;
    logic [PW-1:0] fifo_rptr_q, fifo_rptr_d;
    logic [PW-1:0] pend_wptr_q, pend_wptr_d;
    logic [PW-1:0] pend_rptr_q, pend_rptr_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_pc_d   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [31:0]   fifo_data_d [DEPTH];
    logic [31:0]   pend_pc_q   [DEPTH];
    logic [31:0]   pend_pc_d   [DEPTH];

    // Per-cycle events
    logic [CW:0] occupancy;
    logic        transfer;
    logic        rsp_accept;   // response consumed (kept or dropped)
    logic        rsp_drop;
    logic        rsp_keep;
    logic        pop;

    // The two low redirect bits are deliberately ignored.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Issue and event decode
    always_comb begin
        occupancy  = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req   = reset_n && !redirect_valid && (occupancy < DEPTH_C);
        imem_addr  = fetch_pc_q;
        transfer   = imem_req && imem_gnt;
        // rvalid with nothing outstanding is a protocol error and is ignored.
        rsp_accept = imem_rvalid && (outstanding_q != '0);
        // A response landing in the redirect cycle belongs to the old stream.
        rsp_drop   = rsp_accept && ((discard_q != '0) || redirect_valid);
        rsp_keep   = rsp_accept && !rsp_drop;
        pop        = inst_valid && inst_ready && !redirect_valid;
    end

    // Head of FIFO toward decode
    always_comb begin
        inst_valid = (count_q != '0);
        inst_data  = fifo_data_q[fifo_rptr_q];
        inst_pc    = fifo_pc_q[fifo_rptr_q];
    end

    // Next-state logic
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(transfer) - CW'(rsp_accept);
        discard_d     = discard_q;
        count_d       = count_q;
        fifo_wptr_d   = fifo_wptr_q;
        fifo_rptr_d   = fifo_rptr_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_data_d   = fifo_data_q;
        pend_wptr_d   = pend_wptr_q;
        pend_rptr_d   = pend_rptr_q;
        pend_pc_d     = pend_pc_q;

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (transfer) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        // Everything still outstanding after this cycle's accounting is stale.
        if (redirect_valid) begin
            discard_d = outstanding_d;
        end else if (rsp_accept && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        // The pending-PC queue tracks every outstanding request, including
        // squashed ones, so it drains through the discard path as well.
        if (transfer) begin
            pend_pc_d[pend_wptr_q] = fetch_pc_q;
            pend_wptr_d            = pend_wptr_q + PW'(1);
        end
        if (rsp_accept) begin
            pend_rptr_d = pend_rptr_q + PW'(1);
        end

        if (redirect_valid) begin
            count_d     = '0;
            fifo_wptr_d = '0;
            fifo_rptr_d = '0;
        end else begin
            if (rsp_keep) begin
                fifo_pc_d[fifo_wptr_q]   = pend_pc_q[pend_rptr_q];
                fifo_data_d[fifo_wptr_q] = imem_rdata;
                fifo_wptr_d              = fifo_wptr_q + PW'(1);
            end
            if (pop) begin
                fifo_rptr_d = fifo_rptr_q + PW'(1);
            end
            count_d = count_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            fifo_wptr_q   <= '0;
            fifo_rptr_q   <= '0;
            pend_wptr_q   <= '0;
            pend_rptr_q   <= '0;
            fifo_pc_q     <= '{default: '0};
            fifo_data_q   <= '{default: '0};
            pend_pc_q     <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fifo_wptr_q   <= fifo_wptr_d;
            fifo_rptr_q   <= fifo_rptr_d;
            pend_wptr_q   <= pend_wptr_d;
            pend_rptr_q   <= pend_rptr_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_data_q   <= fifo_data_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_squashed_q, perf_squashed_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q + 32'(rsp_keep);
        perf_squashed_d = perf_squashed_q + 32'(rsp_drop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q  <= '0;
            perf_squashed_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_squashed_q <= perf_squashed_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_squashed = perf_squashed_q;
`endif

`ifndef SYNTHESIS
    a_rvalid_needs_outstanding : assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> (outstanding_q != '0)
    ) else $error("imem_rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Bench for instr_fetch_unit. An in-order memory model returns word = addr
// after a per-test latency; every granted address is pushed to exp_q and
// compared when decode pops the head. A redirect empties exp_q, since all
// older fetches must be squashed. A reference fetch PC (next_addr) is
// checked against imem_addr on each grant.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef IFU_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          n_checks;
    int          n_fail;
    int          cyc;
    logic [31:0] exp_q[$];
    logic [31:0] mem_q[$];
    int          mem_due_q[$];
    int          last_due;
    int unsigned dmin;
    int unsigned dmax;
    bit          mem_hold;
    logic [31:0] next_addr;
    bit          last_req;
    bit          last_grant;
    bit          last_valid;
    bit          last_pop;
    logic [31:0] last_addr;
    logic [31:0] last_pop_pc;

    // ---------------- driver tasks ----------------
    // Asserts reset and clears memory/scoreboard; returns at a falling edge
    // with reset still asserted.
    task automatic apply_reset();
        reset_n        = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        mem_hold       = 1'b0;
        dmin           = 1;
        dmax           = 1;
        mem_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        last_due  = 0;
        next_addr = RESET_PC;
        cyc       = 0;
        repeat (2) @(negedge clk);
    endtask

    // One clock cycle: drive the memory response, sample outputs, update the
    // scoreboard and reference PC, then advance to the next falling edge.
    task automatic step();
        logic [31:0] exp;
        int          due;
        cyc++;
        if (!mem_hold && mem_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_q.pop_front();
            void'(mem_due_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        last_req   = imem_req;
        last_grant = imem_req && imem_gnt;
        last_addr  = imem_addr;
        last_valid = inst_valid;
        last_pop   = 1'b0;
        if (redirect_valid) begin
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL redirect_req: imem_req=%b, required 0", imem_req);
            end
            exp_q.delete();
            next_addr = {redirect_pc[31:2], 2'b00};
        end else begin
            if (inst_valid && inst_ready) begin
                last_pop    = 1'b1;
                last_pop_pc = inst_pc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: popped pc=%h data=%h, none expected", inst_pc, inst_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (inst_pc !== exp || inst_data !== exp) begin
                        n_fail++;
                        $display("FAIL sb_pop: pc=%h data=%h, required %h", inst_pc, inst_data, exp);
                    end
                end
            end
            if (imem_req && imem_gnt) begin
                n_checks++;
                if (imem_addr !== next_addr) begin
                    n_fail++;
                    $display("FAIL grant_addr: imem_addr=%h, required %h", imem_addr, next_addr);
                end
                exp_q.push_back(next_addr);
                mem_q.push_back(imem_addr);
                due = cyc + int'($urandom_range(dmax, dmin));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_due_q.push_back(due);
                next_addr = next_addr + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Stops new fetches and lets everything outstanding reach decode.
    task automatic drain(input int budget);
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < budget && (exp_q.size() > 0 || mem_q.size() > 0); i++) step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d instructions never delivered, required 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: req=%b addr=%h valid=%b data=%h pc=%h, required 0 %h 0 0 0",
                     imem_req, imem_addr, inst_valid, inst_data, inst_pc, RESET_PC);
        end
`ifdef IFU_PERF_EN
        n_checks++;
        if (perf_fetched !== 32'h0 || perf_squashed !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_perf: fetched=%0d squashed=%0d, required 0 0", perf_fetched, perf_squashed);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        step();
        n_checks++;
        if (last_req !== 1'b1 || last_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: req=%b addr=%h, required 1 %h", last_req, last_addr, RESET_PC);
        end
    endtask

    task automatic test_streaming();
        apply_reset();
        reset_n    = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (cyc < 3) begin
                if (last_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stream_early: cycle %0d inst_valid=%b, required 0", cyc, last_valid);
                end
            end else if (last_valid !== 1'b1 || last_pop_pc !== 32'((cyc - 3) * 4)) begin
                n_fail++;
                $display("FAIL stream_seq: cycle %0d valid=%b pc=%h, required 1 %h",
                         cyc, last_valid, last_pop_pc, 32'((cyc - 3) * 4));
            end
        end
        drain(20);
    endtask

    task automatic test_back_pressure();
        int          grants;
        logic [31:0] popped[$];
        logic [31:0] resume_addr;
        bit          resumed;
        apply_reset();
        reset_n    = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b0;
        grants     = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_grant) grants++;
        end
        n_checks++;
        if (grants != DEPTH || last_req !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_grants: grants=%0d req=%b, required %0d 0", grants, last_req, DEPTH);
        end
        inst_ready = 1'b1;
        resumed    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (last_pop) popped.push_back(last_pop_pc);
            if (last_grant && !resumed) begin
                resumed     = 1'b1;
                resume_addr = last_addr;
            end
        end
        n_checks++;
        if (popped.size() < 4 || popped[0] !== 32'd0 || popped[1] !== 32'd4 ||
            popped[2] !== 32'd8 || popped[3] !== 32'd12) begin
            n_fail++;
            $display("FAIL bp_drain_order: %0d pops, first four %p, required 0 4 8 12", popped.size(), popped);
        end
        n_checks++;
        if (!resumed || resume_addr !== 32'd16) begin
            n_fail++;
            $display("FAIL bp_resume: resumed=%b addr=%h, required 1 00000010", resumed, resume_addr);
        end
        drain(20);
    endtask

    task automatic test_redirect();
        bit          found;
        logic [31:0] first_pc;
        apply_reset();
        reset_n    = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b0;
        repeat (3) step();        // grants 0,4,8; responses 0,4 buffered
        mem_hold = 1'b1;
        step();                   // grant 12; 8 and 12 now in flight
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        inst_ready     = 1'b1;
        step();
        n_checks++;
        if (last_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush: inst_valid=%b after redirect, required 0", last_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step();
            if (last_pop) begin
                found    = 1'b1;
                first_pc = last_pop_pc;
            end
        end
        n_checks++;
        if (!found || first_pc !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL redir_first: found=%b pc=%h, required 1 00000100", found, first_pc);
        end
        drain(20);
`ifdef IFU_PERF_EN
        n_checks++;
        if (perf_squashed !== 32'd2) begin
            n_fail++;
            $display("FAIL redir_perf: perf_squashed=%0d, required 2", perf_squashed);
        end
`endif
    endtask

    task automatic test_grant_stalls();
        int grants;
        int pops;
        apply_reset();
        reset_n = 1'b1;
        dmin    = 1;
        dmax    = 3;
        grants  = 0;
        pops    = 0;
        for (int i = 0; i < 64; i++) begin
            imem_gnt   = (i % 4 == 0) || (i % 4 == 3);
            inst_ready = ($urandom_range(3, 0) != 0);
            step();
            if (last_grant) grants++;
            if (last_pop) pops++;
        end
        imem_gnt   = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 40 && (exp_q.size() > 0 || mem_q.size() > 0); i++) begin
            step();
            if (last_pop) pops++;
        end
        n_checks++;
        if (grants == 0 || pops != grants) begin
            n_fail++;
            $display("FAIL stall_count: delivered %0d of %0d granted, required all", pops, grants);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] addrs[$];
        apply_reset();
        reset_n    = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6 && addrs.size() < 2; i++) begin
            step();
            if (last_grant) addrs.push_back(last_addr);
        end
        n_checks++;
        if (addrs.size() != 2 || addrs[0] !== 32'hFFFF_FFFC || addrs[1] !== 32'h0000_0000) begin
            n_fail++;
            $display("FAIL wrap_addr: grants %p, required fffffffc 00000000", addrs);
        end
        drain(20);
    endtask

    task automatic test_async_reset();
        apply_reset();
        reset_n    = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        repeat (6) step();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== RESET_PC || inst_valid !== 1'b0 ||
            inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b addr=%h valid=%b data=%h pc=%h, required 0 %h 0 0 0",
                     imem_req, imem_addr, inst_valid, inst_data, inst_pc, RESET_PC);
        end
        apply_reset();
        reset_n    = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        step();
        n_checks++;
        if (last_grant !== 1'b1 || last_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL async_restart: grant=%b addr=%h, required 1 %h", last_grant, last_addr, RESET_PC);
        end
        repeat (6) step();
        drain(20);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset_n        = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_redirect();
        test_grant_stalls();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
